noc_qos_port_arbiter: RTL and testbench

NOC_QOS_PORT_ARBITER -- requirements
Module: noc_qos_port_arbiter

---
 rtl/noc_qos_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_noc_qos_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_qos_port_arbiter.sv
// NoC output-port arbiter: packet locking, QoS priority with age escalation,
// round-robin tie-break and credit-based downstream flow control.
module noc_qos_port_arbiter #(
   parameter int NUM_IN     = 4,
   parameter int FLIT_LEN   = 256,
   parameter int QOS_W      = 4,
   parameter int CREDIT_MAX = 4,
   parameter int AGE_LIMIT  = 15,
   localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int CW = $clog2(CREDIT_MAX + 1),
   localparam int AW = $clog2(AGE_LIMIT + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN-1:0]            in_valid,
   input  logic [NUM_IN*FLIT_LEN-1:0]   in_flit,
   input  logic [NUM_IN*QOS_W-1:0]      in_qos,
   input  logic [NUM_IN-1:0]            in_last,
   output logic [NUM_IN-1:0]            in_ready,
   output logic                         out_valid,
   output logic [FLIT_LEN-1:0]          out_flit,
   output logic                         out_last,
   output logic [IW-1:0]                out_src,
   input  logic                         credit_return,
   output logic [CW-1:0]                credit_cnt,
   output logic                         credit_err
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            r_state;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_rr;
   logic [AW-1:0]     r_age [NUM_IN];
   logic [CW-1:0]     r_credit;
   logic              r_err;

   logic [NUM_IN-1:0] w_aged;
   logic [NUM_IN-1:0] w_cand;
   logic [QOS_W-1:0]  w_max_qos;
   logic [IW-1:0]     w_win;
   logic              w_any;
   logic [IW-1:0]     w_src;
   logic              w_can;
   logic              w_xfer;
   logic              w_last;
   logic [FLIT_LEN-1:0] w_flit;
   logic [IW-1:0]     w_rr_nxt;

   // Find starved inputs and the highest QoS among valid inputs
   always_comb begin
      w_aged    = '0;
      w_max_qos = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         w_aged[i] = in_valid[i] && (r_age[i] == AW'(AGE_LIMIT));
         if (in_valid[i] && (in_qos[i*QOS_W +: QOS_W] > w_max_qos))
            w_max_qos = in_qos[i*QOS_W +: QOS_W];
      end
   end

   // Candidate set: starved inputs override QoS ranking
   always_comb begin
      w_cand = '0;
      for (int i = 0; i < NUM_IN; i++)
         w_cand[i] = in_valid[i] && (in_qos[i*QOS_W +: QOS_W] == w_max_qos);
      if (|w_aged)
         w_cand = w_aged;
   end

   // Round-robin pick among candidates starting at r_rr
   always_comb begin
      int            idx;
      logic [IW-1:0] sel;
      idx   = 0;
      sel   = '0;
      w_win = '0;
      w_any = 1'b0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         idx = int'(r_rr) + k;
         if (idx >= NUM_IN)
            idx = idx - NUM_IN;
         sel = IW'(idx);
         if (w_cand[sel]) begin
            w_win = sel;
            w_any = 1'b1;
         end
      end
   end

   assign w_src  = (r_state == S_LOCKED) ? r_owner : w_win;
   assign w_can  = !rst && (r_credit != '0);
   assign w_last = in_last[w_src];
   assign w_flit = in_flit[int'(w_src)*FLIT_LEN +: FLIT_LEN];
   assign w_rr_nxt = (w_src == IW'(NUM_IN - 1)) ? '0 : w_src + 1'b1;

   // Grant: owner while locked, arbitration winner while idle
   always_comb begin
      in_ready = '0;
      if (w_can) begin
         if (r_state == S_LOCKED)
            in_ready[r_owner] = 1'b1;
         else if (w_any)
            in_ready[w_win] = 1'b1;
      end
   end

   assign w_xfer = |(in_valid & in_ready);

   // Port FSM, round-robin pointer and registered output flit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_owner   <= '0;
         r_rr      <= '0;
         out_valid <= 1'b0;
         out_flit  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else begin
         out_valid <= w_xfer;
         if (w_xfer) begin
            out_flit <= w_flit;
            out_last <= w_last;
            out_src  <= w_src;
            if (w_last) begin
               r_state <= S_IDLE;
               r_rr    <= w_rr_nxt;
            end else begin
               r_state <= S_LOCKED;
               r_owner <= w_src;
            end
         end
      end
   end

   // Downstream credit counter with sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credit <= CW'(CREDIT_MAX);
         r_err    <= 1'b0;
      end else if (w_xfer && !credit_return) begin
         r_credit <= r_credit - 1'b1;
      end else if (!w_xfer && credit_return) begin
         if (r_credit == CW'(CREDIT_MAX))
            r_err <= 1'b1;
         else
            r_credit <= r_credit + 1'b1;
      end
   end

   // Per-input wait age, cleared when a packet completes
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (rst)
            r_age[i] <= '0;
         else if (w_xfer && (w_src == IW'(i))) begin
            if (w_last)
               r_age[i] <= '0;
         end else if (in_valid[i] && (r_age[i] != AW'(AGE_LIMIT)))
            r_age[i] <= r_age[i] + 1'b1;
      end
   end

   assign credit_cnt = r_credit;
   assign credit_err = r_err;

endmodule

// File: tb/tb_noc_qos_port_arbiter.sv
// Directed bench for noc_qos_port_arbiter: arbitration order, locking,
// credits, starvation escape and mid-packet reset.
module tb_noc_qos_port_arbiter;

   localparam int N  = 4;
   localparam int FL = 256;
   localparam int QW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_valid;
   logic [N*FL-1:0] in_flit;
   logic [N*QW-1:0] in_qos;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [FL-1:0]   out_flit;
   logic            out_last;
   logic [1:0]      out_src;
   logic            credit_return;
   logic [2:0]      credit_cnt;
   logic            credit_err;

   int total = 0;
   int bad   = 0;
   int grant;

   always #5 clk = ~clk;

   noc_qos_port_arbiter #(
      .NUM_IN(N), .FLIT_LEN(FL), .QOS_W(QW), .CREDIT_MAX(4), .AGE_LIMIT(15)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_flit(in_flit), .in_qos(in_qos),
      .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
      .out_src(out_src), .credit_return(credit_return),
      .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   task automatic chk(input string tag, input logic [FL-1:0] obs,
                      input logic [FL-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FL-1:0] mkf(input int s, input int n);
      return {8'(s + 1), 232'd0, 8'(s), 8'(n)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input int i, input logic v, input logic [QW-1:0] q,
                      input logic l, input logic [FL-1:0] f);
      in_valid[i]          = v;
      in_qos[i*QW +: QW]   = q;
      in_last[i]           = l;
      in_flit[i*FL +: FL]  = f;
   endtask

   task automatic clr_all();
      in_valid      = '0;
      in_last       = '0;
      in_qos        = '0;
      in_flit       = '0;
      credit_return = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_all();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      // reset state, with inputs requesting
      rst = 1'b1;
      clr_all();
      in_valid = '1;
      cyc();
      cyc();
      chk("rst_ready", in_ready, 4'b0000);
      chk("rst_ovalid", out_valid, 1'b0);
      chk("rst_oflit", out_flit, '0);
      chk("rst_olast", out_last, 1'b0);
      chk("rst_osrc", out_src, 2'd0);
      chk("rst_credit", credit_cnt, 3'd4);
      chk("rst_err", credit_err, 1'b0);

      // qos 2,7,7,1: input 1 then input 2
      rst = 1'b0;
      set(0, 1, 4'd2, 1, mkf(0, 1));
      set(1, 1, 4'd7, 1, mkf(1, 1));
      set(2, 1, 4'd7, 1, mkf(2, 1));
      set(3, 1, 4'd1, 1, mkf(3, 1));
      #1 chk("a_ready0", in_ready, 4'b0010);
      cyc();
      chk("a_ovalid0", out_valid, 1'b1);
      chk("a_osrc0", out_src, 2'd1);
      chk("a_oflit0", out_flit, mkf(1, 1));
      chk("a_olast0", out_last, 1'b1);
      chk("a_credit0", credit_cnt, 3'd3);
      #1 chk("a_ready1", in_ready, 4'b0100);
      cyc();
      chk("a_osrc1", out_src, 2'd2);
      chk("a_oflit1", out_flit, mkf(2, 1));
      chk("a_credit1", credit_cnt, 3'd2);
      clr_all();
      cyc();
      chk("a_idle_ovalid", out_valid, 1'b0);

      // 3-flit packet from input 0 holds the port against qos 15
      do_reset();
      set(0, 1, 4'd0, 0, mkf(0, 1));
      #1 chk("b_ready0", in_ready, 4'b0001);
      cyc();
      chk("b_osrc0", out_src, 2'd0);
      chk("b_olast0", out_last, 1'b0);
      set(0, 1, 4'd0, 0, mkf(0, 2));
      set(3, 1, 4'd15, 1, mkf(3, 1));
      #1 chk("b_ready1", in_ready, 4'b0001);
      cyc();
      chk("b_osrc1", out_src, 2'd0);
      chk("b_oflit1", out_flit, mkf(0, 2));
      set(0, 1, 4'd0, 1, mkf(0, 3));
      #1 chk("b_ready2", in_ready, 4'b0001);
      cyc();
      chk("b_osrc2", out_src, 2'd0);
      chk("b_olast2", out_last, 1'b1);
      chk("b_ovalid2", out_valid, 1'b1);
      set(0, 0, 4'd0, 0, '0);
      #1 chk("b_ready3", in_ready, 4'b1000);
      cyc();
      chk("b_osrc3", out_src, 2'd3);
      chk("b_credit3", credit_cnt, 3'd0);

      // credit exhaustion after 4 flits, one return releases the 5th
      do_reset();
      for (int n = 0; n < 4; n++) begin
         set(0, 1, 4'd0, 1, mkf(0, n));
         #1 chk("c_ready", in_ready, 4'b0001);
         cyc();
         chk("c_oflit", out_flit, mkf(0, n));
      end
      chk("c_credit0", credit_cnt, 3'd0);
      set(0, 1, 4'd0, 1, mkf(0, 4));
      #1 chk("c_ready_nocred", in_ready, 4'b0000);
      cyc();
      chk("c_ovalid_nocred", out_valid, 1'b0);
      credit_return = 1'b1;
      #1 chk("c_ready_ret", in_ready, 4'b0000);
      cyc();
      credit_return = 1'b0;
      chk("c_credit1", credit_cnt, 3'd1);
      chk("c_ovalid_ret", out_valid, 1'b0);
      #1 chk("c_ready5", in_ready, 4'b0001);
      cyc();
      chk("c_ovalid5", out_valid, 1'b1);
      chk("c_oflit5", out_flit, mkf(0, 4));
      chk("c_credit5", credit_cnt, 3'd0);

      // credit overflow is sticky; simultaneous transfer and return
      do_reset();
      credit_return = 1'b1;
      cyc();
      credit_return = 1'b0;
      chk("d_credit_ovf", credit_cnt, 3'd4);
      chk("d_err_set", credit_err, 1'b1);
      set(0, 1, 4'd0, 1, mkf(0, 0));
      cyc();
      cyc();
      chk("d_credit2", credit_cnt, 3'd2);
      credit_return = 1'b1;
      cyc();
      chk("d_credit_both", credit_cnt, 3'd2);
      chk("d_ovalid_both", out_valid, 1'b1);
      clr_all();
      cyc();
      chk("d_err_sticky", credit_err, 1'b1);

      // reset mid-packet drops the lock and the round-robin pointer
      do_reset();
      set(2, 1, 4'd0, 1, mkf(2, 0));
      #1 chk("e_ready0", in_ready, 4'b0100);
      cyc();
      set(2, 0, 4'd0, 0, '0);
      set(1, 1, 4'd0, 0, mkf(1, 1));
      #1 chk("e_ready1", in_ready, 4'b0010);
      cyc();
      chk("e_osrc1", out_src, 2'd1);
      set(1, 1, 4'd0, 0, mkf(1, 2));
      rst = 1'b1;
      #1 chk("e_ready_rst", in_ready, 4'b0000);
      cyc();
      rst = 1'b0;
      chk("e_ovalid_rst", out_valid, 1'b0);
      chk("e_oflit_rst", out_flit, '0);
      chk("e_credit_rst", credit_cnt, 3'd4);
      set(1, 1, 4'd3, 0, mkf(1, 2));
      set(2, 1, 4'd8, 1, mkf(2, 1));
      set(3, 1, 4'd8, 1, mkf(3, 1));
      #1 chk("e_ready_new", in_ready, 4'b0100);
      cyc();
      chk("e_osrc_new", out_src, 2'd2);

      // low-qos input 0 escapes starvation through its age counter
      do_reset();
      set(0, 1, 4'd1, 1, mkf(0, 0));
      set(1, 1, 4'd9, 1, mkf(1, 0));
      set(2, 1, 4'd9, 1, mkf(2, 0));
      grant = -1;
      for (int k = 0; k < 20; k++) begin
         credit_return = out_valid;
         #1;
         if (k == 0)
            chk("f_ready_k0", in_ready, 4'b0010);
         if (k == 1)
            chk("f_ready_k1", in_ready, 4'b0100);
         if (in_ready[0] && grant < 0)
            grant = k;
         cyc();
      end
      chk("f_grant_cycle", 256'(grant), 256'(15));
      chk("f_err", credit_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
